gate_vector_checker: RTL and testbench
======================================

GATE_VECTOR_CHECKER -- requirements
Module: gate_vector_checker

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 2, number of clk cycles the DUT inputs are held before y_in is sampled (legal 1..15).
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 SHALL have port start  input  1  one-cycle request to run a full check.
REQ-005 SHALL have port gate_sel  input  3  expected gate function: 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR, 6-7 reserved.
REQ-006 SHALL have port y_in  input  1  output of the external 2-input gate under check.
REQ-007 SHALL have port a_out  output  1  drive to the DUT input a.
REQ-008 SHALL have port b_out  output  1  drive to the DUT input b.
REQ-009 SHALL have port busy  output  1  high while a check is in progress.
REQ-010 SHALL have port done  output  1  high when results are valid; held until the next accepted start or rst.
REQ-011 SHALL have port pass  output  1  valid with done: 1 = all four vectors matched.
REQ-012 SHALL have port err_count  output  3  number of mismatching vectors (0..4).
REQ-013 SHALL have port fail_vec  output  2  {a,b} of the first mismatching vector; 0 when err_count = 0.
REQ-014 SHALL have port cfg_err  output  1  set with done when the latched gate_sel was reserved.

Function
REQ-015 SHALL implement states IDLE, SETTLE, SAMPLE, DONE.
REQ-016 SHALL accept start only in IDLE or DONE; start while busy SHALL be ignored.
REQ-017 On an accepted start SHALL: latch gate_sel; clear err_count, fail_vec, pass, done, cfg_err; set vector index to 0; drive {a_out,b_out} = 2'b00; enter SETTLE with settle counter 0.
REQ-018 If the latched gate_sel is 6 or 7, SHALL instead go directly to DONE on the next edge with cfg_err=1, pass=0, err_count=0, a_out=b_out=0.
REQ-019 SETTLE: counter increments each cycle; on the cycle the counter equals SETTLE_CYCLES-1, next state SHALL be SAMPLE.
REQ-020 SAMPLE lasts exactly one cycle; y_in SHALL be compared at the edge leaving SAMPLE against the expected function of the current {a_out,b_out}.
REQ-021 On mismatch SHALL increment err_count, and record fail_vec only if err_count was 0.
REQ-022 Vector order SHALL be 00, 01, 10, 11 ({a,b}); after SAMPLE of vectors 0..2, SHALL drive the next vector and re-enter SETTLE with counter 0.
REQ-023 After SAMPLE of vector 11, SHALL enter DONE with pass = (final err_count == 0) and done=1.
REQ-024 Each vector SHALL occupy exactly SETTLE_CYCLES+1 cycles; done SHALL rise 4*(SETTLE_CYCLES+1) edges after the start edge (12 for default).
REQ-025 busy SHALL be 1 exactly in SETTLE and SAMPLE; done SHALL be 1 exactly in DONE.
REQ-026 a_out/b_out SHALL be registered, SHALL keep the last vector in DONE, and SHALL be 0 in IDLE.
REQ-027 A start accepted in DONE SHALL restart identically to one from IDLE (same edge, same timing).
REQ-028 y_in SHALL be ignored outside SAMPLE.

Reset
REQ-029 When rst=1 at a clock edge SHALL enter IDLE and set a_out, b_out, busy, done, pass, err_count, fail_vec, cfg_err to 0, counters to 0.
REQ-030 Reset SHALL take priority over start and SHALL abort a check in progress without setting done.
REQ-031 start asserted in the same cycle as rst SHALL be ignored.

Verification
REQ-032 gate_sel=0, y_in = a&b from a model AND gate, start pulse -> a_out/b_out step 00,01,10,11 every 3 cycles; done at edge 12; pass=1, err_count=0, fail_vec=0.
REQ-033 gate_sel=0, y_in tied 1 -> done at edge 12, pass=0, err_count=3, fail_vec=2'b00.
REQ-034 gate_sel=2 (XOR), model XNOR on y_in -> pass=0, err_count=4, fail_vec=2'b00; restart with model XOR -> pass=1, err_count=0.
REQ-035 start re-pulsed at edges 4 and 7 of a run -> ignored; done still at edge 12, results unchanged.
REQ-036 rst=1 at edge 6 of a run -> next cycle busy=0, done=0, a_out=b_out=0; fresh start runs full 12-cycle check.
REQ-037 gate_sel=7, start -> next edge done=1, cfg_err=1, pass=0, busy never asserted.

Source files
------------

// File: rtl/gate_vector_checker.sv
// Drives all four {a,b} vectors into an external 2-input gate and checks y_in against the selected function.
// Latency 4*(SETTLE_CYCLES+1) cycles from accepted start to done; start is dropped while busy.
module gate_vector_checker #(
   parameter int SETTLE_CYCLES = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [2:0] gate_sel,
   input  logic       y_in,
   output logic       a_out,
   output logic       b_out,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [2:0] err_count,
   output logic [1:0] fail_vec,
   output logic       cfg_err
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_SETTLE = 2'd1;
   localparam logic [1:0] S_SAMPLE = 2'd2;
   localparam logic [1:0] S_DONE   = 2'd3;

   logic [1:0] r_state;
   logic [3:0] r_cnt;
   logic [1:0] r_vec;
   logic [2:0] r_sel;
   logic [2:0] r_err;
   logic [1:0] r_fail;
   logic       r_pass;
   logic       r_cfg;

   logic       w_accept;
   logic       w_reserved;
   logic       w_exp;
   logic       w_mism;
   logic [2:0] w_err_nxt;
   logic [3:0] w_last_cnt;

   function automatic logic f_expect(input logic [2:0] sel, input logic a, input logic b);
      case (sel)
         3'd0:    return a & b;
         3'd1:    return a | b;
         3'd2:    return a ^ b;
         3'd3:    return ~(a & b);
         3'd4:    return ~(a | b);
         3'd5:    return ~(a ^ b);
         default: return 1'b0;
      endcase
   endfunction

   assign w_accept   = start && ((r_state == S_IDLE) || (r_state == S_DONE));
   assign w_reserved = gate_sel[2] & gate_sel[1];
   assign w_exp      = f_expect(r_sel, r_vec[1], r_vec[0]);
   assign w_mism     = (y_in != w_exp);
   assign w_err_nxt  = r_err + {2'b00, w_mism};
   assign w_last_cnt = 4'(SETTLE_CYCLES - 1);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_vec   <= '0;
         r_sel   <= '0;
         r_err   <= '0;
         r_fail  <= '0;
         r_pass  <= 1'b0;
         r_cfg   <= 1'b0;
      end else if (w_accept) begin
         // Reserved selects report straight away without driving any vectors
         r_sel   <= gate_sel;
         r_vec   <= '0;
         r_cnt   <= '0;
         r_err   <= '0;
         r_fail  <= '0;
         r_pass  <= 1'b0;
         r_cfg   <= w_reserved;
         r_state <= w_reserved ? S_DONE : S_SETTLE;
      end else begin
         case (r_state)
            S_SETTLE: begin
               if (r_cnt == w_last_cnt) r_state <= S_SAMPLE;
               else                     r_cnt   <= r_cnt + 4'd1;
            end
            S_SAMPLE: begin
               r_err <= w_err_nxt;
               if (w_mism && (r_err == 3'd0)) r_fail <= r_vec;
               if (r_vec == 2'b11) begin
                  r_pass  <= (w_err_nxt == 3'd0);
                  r_state <= S_DONE;
               end else begin
                  r_vec   <= r_vec + 2'd1;
                  r_cnt   <= '0;
                  r_state <= S_SETTLE;
               end
            end
            default: ;
         endcase
      end
   end

   assign a_out     = r_vec[1];
   assign b_out     = r_vec[0];
   assign busy      = (r_state == S_SETTLE) || (r_state == S_SAMPLE);
   assign done      = (r_state == S_DONE);
   assign pass      = r_pass;
   assign err_count = r_err;
   assign fail_vec  = r_fail;
   assign cfg_err   = r_cfg;

endmodule

// File: tb/tb_gate_vector_checker.sv
// Directed runs against a model gate; expected results are queued at start and checked when done rises.
module tb_gate_vector_checker;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [2:0] gate_sel;
   logic       y_in;
   logic       a_out, b_out, busy, done, pass, cfg_err;
   logic [2:0] err_count;
   logic [1:0] fail_vec;

   gate_vector_checker #(.SETTLE_CYCLES(2)) dut (
      .clk(clk), .rst(rst), .start(start), .gate_sel(gate_sel), .y_in(y_in),
      .a_out(a_out), .b_out(b_out), .busy(busy), .done(done), .pass(pass),
      .err_count(err_count), .fail_vec(fail_vec), .cfg_err(cfg_err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_vec = 0;
   int n_err = 0;

   typedef struct {
      int         done_cyc;
      logic       pass;
      logic [2:0] err;
      logic [1:0] fail;
      logic       cfg;
      logic [1:0] last;
   } exp_t;

   exp_t sb[$];
   exp_t e;

   logic       y_tied;
   logic [2:0] model_sel;

   // Reference behaviour of the external gate being exercised
   function automatic logic gate_fn(input logic [2:0] sel, input logic a, input logic b);
      case (sel)
         3'd0:    return a & b;
         3'd1:    return a | b;
         3'd2:    return a ^ b;
         3'd3:    return ~(a & b);
         3'd4:    return ~(a | b);
         3'd5:    return ~(a ^ b);
         default: return 1'b0;
      endcase
   endfunction

   assign y_in = y_tied ? 1'b1 : gate_fn(model_sel, a_out, b_out);

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, req, cyc);
      end
   endtask

   logic prev_done = 1'b0;
   always @(negedge clk) begin
      if (done === 1'b1 && prev_done !== 1'b1) begin
         if (sb.size() == 0) begin
            check("unexpected_done", 32'd1, 32'd0);
         end else begin
            e = sb.pop_front();
            check("done_cycle", cyc, e.done_cyc);
            check("pass", {31'd0, pass}, {31'd0, e.pass});
            check("err_count", {29'd0, err_count}, {29'd0, e.err});
            check("fail_vec", {30'd0, fail_vec}, {30'd0, e.fail});
            check("cfg_err", {31'd0, cfg_err}, {31'd0, e.cfg});
            check("last_vec", {30'd0, a_out, b_out}, {30'd0, e.last});
         end
      end
      prev_done <= done;
   end

   // Called at a negedge; returns at the negedge just after the start edge.
   task automatic launch(input logic [2:0] sel, input logic tied, input logic [2:0] msel,
                         input bit push, input int lat, input logic xp, input logic [2:0] xe,
                         input logic [1:0] xf, input logic xc, input logic [1:0] xl);
      exp_t x;
      gate_sel  = sel;
      y_tied    = tied;
      model_sel = msel;
      if (push) begin
         x.done_cyc = cyc + 1 + lat;
         x.pass = xp; x.err = xe; x.fail = xf; x.cfg = xc; x.last = xl;
         sb.push_back(x);
      end
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; gate_sel = 3'd0; y_tied = 1'b0; model_sel = 3'd0;
      idle(3);
      check("reset_outputs", {18'd0, a_out, b_out, busy, done, pass, err_count, fail_vec, cfg_err, 3'd0}, 32'd0);
      rst = 1'b0;
      idle(1);

      // AND against a good AND gate, with vector stepping checked every 3 cycles
      launch(3'd0, 1'b0, 3'd0, 1'b1, 12, 1'b1, 3'd0, 2'b00, 1'b0, 2'b11);
      check("busy_after_start", {31'd0, busy}, 32'd1);
      for (int k = 0; k < 12; k++) begin
         if (k % 3 == 0) check("vec_step", {30'd0, a_out, b_out}, 32'(k / 3));
         @(negedge clk);
      end
      idle(2);

      // AND against a stuck-at-1 output
      launch(3'd0, 1'b1, 3'd0, 1'b1, 12, 1'b0, 3'd3, 2'b00, 1'b0, 2'b11);
      idle(14);

      // XOR expected, XNOR present; then restart from DONE with a correct XOR
      launch(3'd2, 1'b0, 3'd5, 1'b1, 12, 1'b0, 3'd4, 2'b00, 1'b0, 2'b11);
      idle(14);
      launch(3'd2, 1'b0, 3'd2, 1'b1, 12, 1'b1, 3'd0, 2'b00, 1'b0, 2'b11);
      check("done_clears_on_restart", {31'd0, done}, 32'd0);
      idle(14);

      // NOR expected, XNOR present (only 11 differs); start re-pulsed at edges 4 and 7
      launch(3'd4, 1'b0, 3'd5, 1'b1, 12, 1'b0, 3'd1, 2'b11, 1'b0, 2'b11);
      idle(3);
      gate_sel = 3'd0;
      start = 1'b1; @(negedge clk); start = 1'b0;
      check("busy_during_repulse", {31'd0, busy}, 32'd1);
      idle(2);
      start = 1'b1; @(negedge clk); start = 1'b0;
      idle(7);

      // Reset at edge 6 aborts the run without reporting
      launch(3'd1, 1'b0, 3'd0, 1'b0, 0, 1'b0, 3'd0, 2'b00, 1'b0, 2'b00);
      idle(5);
      rst = 1'b1; @(negedge clk); rst = 1'b0;
      check("abort_busy", {31'd0, busy}, 32'd0);
      check("abort_done", {31'd0, done}, 32'd0);
      check("abort_ab", {30'd0, a_out, b_out}, 32'd0);
      rst = 1'b1; start = 1'b1; @(negedge clk); rst = 1'b0; start = 1'b0;
      check("start_with_rst_ignored", {31'd0, busy}, 32'd0);

      // OR expected, AND present: 01 and 10 mismatch
      launch(3'd1, 1'b0, 3'd0, 1'b1, 12, 1'b0, 3'd2, 2'b01, 1'b0, 2'b11);
      idle(14);

      // Reserved select reports on the start edge itself
      rst = 1'b1; @(negedge clk); rst = 1'b0;
      launch(3'd7, 1'b0, 3'd0, 1'b1, 0, 1'b0, 3'd0, 2'b00, 1'b1, 2'b00);
      for (int k = 0; k < 4; k++) begin
         check("cfg_busy_low", {31'd0, busy}, 32'd0);
         @(negedge clk);
      end

      check("scoreboard_drained", sb.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
